exec_datapath: RTL and testbench

EXEC_DATAPATH -- requirements
Module: exec_datapath

---
 rtl/exec_dp_pkg.sv | 41 ++++
 rtl/exec_datapath_mul_iter.sv | 51 +++++
 rtl/exec_datapath.sv | 246 ++++++++++++++++++++++++
 tb/tb_exec_datapath.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/exec_dp_pkg.sv
// Shared types for the execute datapath: operation encodings, operand-source
// selectors, sequencer states and NZCV bit positions.
package exec_dp_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_EOR = 3'b100,
    ALU_MOV = 3'b101,
    ALU_MVN = 3'b110,
    ALU_RSB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  // FWD_ALT selects pc for A, imm for B and zero for S.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_RES = 2'b01,
    FWD_LDR = 2'b10,
    FWD_ALT = 2'b11
  } fwd_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/exec_datapath_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_W cycles,
// low DATA_W bits of the product presented combinationally alongside done.
module mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CW = $clog2(DATA_W);

  logic              busy;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc_next;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  // The last partial product is folded in on the done cycle itself.
  assign done     = busy && (cnt == '0);
  assign product  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(DATA_W - 1);
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_datapath.sv
// Two-stage execute datapath: operand capture into stage 1, then shift+ALU into
// the result register (or an iterative multiply), with NZCV and regfile writeback.
// Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
// in_valid is ignored whenever in_ready is low.
module exec_datapath
  import exec_dp_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREG   = 16,
  parameter  int PC_W   = 11,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     a_addr,
  input  logic [AW-1:0]     b_addr,
  input  logic [AW-1:0]     s_addr,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [1:0]        fwd_s,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] imm,
  input  logic [1:0]        shift_op,
  input  logic              sel_shift_reg,
  input  logic [7:0]        shift_imm,
  input  logic [2:0]        alu_op,
  input  logic              mul,
  input  logic              set_flags,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic              ldr_en,
  input  logic [AW-1:0]     ldr_addr,
  input  logic [DATA_W-1:0] ldr_data,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [3:0]        status
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] rf [NREG];

  state_e state_q, state_d;
  logic   fire, mul_start, mul_done;
  logic [DATA_W-1:0] mul_product;

  // Stage 1. Result-register forwarding is resolved at execute time so a
  // dependent op issued back-to-back sees the value registered one edge earlier.
  logic              s1_valid, s1_mul, s1_set_flags, s1_wb_en, s1_sel_shift_reg;
  logic              s1_a_res, s1_b_res, s1_s_res;
  logic [DATA_W-1:0] s1_a, s1_b;
  logic [7:0]        s1_s, s1_shift_imm;
  logic [AW-1:0]     s1_wb_addr;
  shift_op_e         s1_shift_op;
  alu_op_e           s1_alu_op;

  logic              res_wb_en;
  logic [AW-1:0]     res_wb_addr;

  logic [DATA_W-1:0] cap_a, cap_b;
  logic [7:0]        cap_s;
  logic [DATA_W-1:0] op_a, op_b, b_sh, x, y, alu_res;
  logic [7:0]        op_s, amt, rot;
  logic [DATA_W:0]   sum;
  logic              cin, arith;
  logic [3:0]        alu_flags;

  assign fire     = in_valid && in_ready;
  assign in_ready = (state_q == ST_IDLE) && !(s1_valid && s1_mul);

  always_comb begin
    cap_a = '0;
    cap_b = '0;
    cap_s = '0;
    case (fwd_e'(fwd_a))
      FWD_RF:  cap_a = rf[a_addr];
      FWD_LDR: cap_a = ldr_data;
      FWD_ALT: cap_a = {{(DATA_W-PC_W){1'b0}}, pc};
      default: cap_a = '0;
    endcase
    case (fwd_e'(fwd_b))
      FWD_RF:  cap_b = rf[b_addr];
      FWD_LDR: cap_b = ldr_data;
      FWD_ALT: cap_b = imm;
      default: cap_b = '0;
    endcase
    case (fwd_e'(fwd_s))
      FWD_RF:  cap_s = rf[s_addr][7:0];
      FWD_LDR: cap_s = ldr_data[7:0];
      default: cap_s = '0;
    endcase
  end

  assign op_a = s1_a_res ? result : s1_a;
  assign op_b = s1_b_res ? result : s1_b;
  assign op_s = s1_s_res ? result[7:0] : s1_s;

  always_comb begin
    amt  = s1_sel_shift_reg ? op_s : s1_shift_imm;
    rot  = 8'(int'(amt) % DATA_W);
    b_sh = op_b;
    if (amt != '0) begin
      case (s1_shift_op)
        SH_LSL: b_sh = (int'(amt) >= DATA_W) ? '0 : op_b << amt;
        SH_LSR: b_sh = (int'(amt) >= DATA_W) ? '0 : op_b >> amt;
        SH_ASR: b_sh = (int'(amt) >= DATA_W) ? {DATA_W{op_b[MSB]}}
                                             : DATA_W'($signed(op_b) >>> amt);
        default: b_sh = (op_b >> rot) | (op_b << (DATA_W - int'(rot)));
      endcase
    end
  end

  // SUB and RSB are x + ~y + 1, so carry-out means "no borrow".
  always_comb begin
    x     = op_a;
    y     = b_sh;
    cin   = 1'b0;
    arith = 1'b0;
    case (s1_alu_op)
      ALU_ADD: arith = 1'b1;
      ALU_SUB: begin y = ~b_sh; cin = 1'b1; arith = 1'b1; end
      ALU_RSB: begin x = b_sh; y = ~op_a; cin = 1'b1; arith = 1'b1; end
      default: ;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, cin};
    case (s1_alu_op)
      ALU_AND: alu_res = op_a & b_sh;
      ALU_ORR: alu_res = op_a | b_sh;
      ALU_EOR: alu_res = op_a ^ b_sh;
      ALU_MOV: alu_res = b_sh;
      ALU_MVN: alu_res = ~b_sh;
      default: alu_res = sum[MSB:0];
    endcase
    alu_flags         = status;
    alu_flags[FLAG_N] = alu_res[MSB];
    alu_flags[FLAG_Z] = (alu_res == '0);
    if (arith) begin
      alu_flags[FLAG_C] = sum[DATA_W];
      alu_flags[FLAG_V] = (x[MSB] == y[MSB]) && (sum[MSB] != x[MSB]);
    end
  end

  mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: if (s1_valid && s1_mul) begin
        state_d   = ST_MUL_BUSY;
        mul_start = 1'b1;
      end
      ST_MUL_BUSY: if (mul_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid         <= 1'b0;
      s1_mul           <= 1'b0;
      s1_set_flags     <= 1'b0;
      s1_wb_en         <= 1'b0;
      s1_wb_addr       <= '0;
      s1_sel_shift_reg <= 1'b0;
      s1_shift_imm     <= '0;
      s1_shift_op      <= SH_LSL;
      s1_alu_op        <= ALU_ADD;
      s1_a             <= '0;
      s1_b             <= '0;
      s1_s             <= '0;
      s1_a_res         <= 1'b0;
      s1_b_res         <= 1'b0;
      s1_s_res         <= 1'b0;
      result           <= '0;
      result_valid     <= 1'b0;
      res_wb_en        <= 1'b0;
      res_wb_addr      <= '0;
      status           <= '0;
    end else begin
      result_valid <= 1'b0;
      if (fire) begin
        s1_valid         <= 1'b1;
        s1_mul           <= mul;
        s1_set_flags     <= set_flags;
        s1_wb_en         <= wb_en;
        s1_wb_addr       <= wb_addr;
        s1_sel_shift_reg <= sel_shift_reg;
        s1_shift_imm     <= shift_imm;
        s1_shift_op      <= shift_op_e'(shift_op);
        s1_alu_op        <= alu_op_e'(alu_op);
        s1_a             <= cap_a;
        s1_b             <= cap_b;
        s1_s             <= cap_s;
        s1_a_res         <= (fwd_e'(fwd_a) == FWD_RES);
        s1_b_res         <= (fwd_e'(fwd_b) == FWD_RES);
        s1_s_res         <= (fwd_e'(fwd_s) == FWD_RES);
      end else if (!s1_mul || (state_q == ST_MUL_BUSY && mul_done)) begin
        s1_valid <= 1'b0;
      end

      if (s1_valid && !s1_mul) begin
        result       <= alu_res;
        result_valid <= 1'b1;
        res_wb_en    <= s1_wb_en;
        res_wb_addr  <= s1_wb_addr;
        if (s1_set_flags) status <= alu_flags;
      end else if (state_q == ST_MUL_BUSY && mul_done) begin
        result       <= mul_product;
        result_valid <= 1'b1;
        res_wb_en    <= s1_wb_en;
        res_wb_addr  <= s1_wb_addr;
        if (s1_set_flags) begin
          status[FLAG_N] <= mul_product[MSB];
          status[FLAG_Z] <= (mul_product == '0);
        end
      end
    end
  end

  // Result port is written last so it wins an address collision with ldr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (ldr_en) rf[ldr_addr] <= ldr_data;
      if (result_valid && res_wb_en) rf[res_wb_addr] <= result;
    end
  end

endmodule

// File: tb/tb_exec_datapath.sv
// Directed bench for exec_datapath: ALU/flags, forwarding, shifts, multiply,
// write-port collision and reset during a multiply.
module tb_exec_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  a_addr, b_addr, s_addr, wb_addr, ldr_addr;
  logic [1:0]  fwd_a, fwd_b, fwd_s, shift_op;
  logic [10:0] pc;
  logic [31:0] imm, ldr_data, result;
  logic        sel_shift_reg, mul, set_flags, wb_en, ldr_en, result_valid;
  logic [7:0]  shift_imm;
  logic [2:0]  alu_op;
  logic [3:0]  status;

  int checks = 0;
  int errors = 0;
  int n_edges, ready_seen, rv_seen;

  exec_datapath dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_addr(a_addr), .b_addr(b_addr), .s_addr(s_addr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_s(fwd_s), .pc(pc), .imm(imm),
    .shift_op(shift_op), .sel_shift_reg(sel_shift_reg), .shift_imm(shift_imm),
    .alu_op(alu_op), .mul(mul), .set_flags(set_flags),
    .wb_en(wb_en), .wb_addr(wb_addr),
    .ldr_en(ldr_en), .ldr_addr(ldr_addr), .ldr_data(ldr_data),
    .result(result), .result_valid(result_valid), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic defaults();
    a_addr = 4'd0; b_addr = 4'd0; s_addr = 4'd0;
    fwd_a = 2'b00; fwd_b = 2'b00; fwd_s = 2'b00;
    pc = '0; imm = '0; shift_op = 2'b00; sel_shift_reg = 1'b0; shift_imm = 8'd0;
    alu_op = 3'b000; mul = 1'b0; set_flags = 1'b0; wb_en = 1'b0; wb_addr = 4'd0;
  endtask

  task automatic ldr(input logic [3:0] addr, input logic [31:0] data);
    ldr_en = 1'b1; ldr_addr = addr; ldr_data = data;
    @(posedge clk); #1;
    ldr_en = 1'b0;
  endtask

  // Returns #1 after the capture edge.
  task automatic issue();
    int k = 0;
    while (!in_ready && k < 200) begin @(posedge clk); #1; k++; end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] exp);
    issue();
    @(posedge clk); #1;
    chk(tag, result, exp);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; ldr_en = 1'b0; ldr_addr = '0; ldr_data = '0;
    defaults();
    repeat (2) @(posedge clk); #1;
    chk("rst_result", result, 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    ldr(4'd1, 32'h7FFF_FFFF);
    ldr(4'd2, 32'h0000_0001);
    ldr(4'd6, 32'd36);
    ldr(4'd5, 32'h1111_1111);
    chk("ldr_r5", dut.rf[5], 32'h1111_1111);

    // ADD with overflow, writeback to r3
    defaults(); a_addr = 4'd1; b_addr = 4'd2; set_flags = 1'b1; wb_en = 1'b1; wb_addr = 4'd3;
    run_op("add_result", 32'h8000_0000);
    chk("add_valid", 32'(result_valid), 32'd1);
    chk("add_status", 32'(status), 32'b1001);
    chk("add_r3_pending", dut.rf[3], 32'd0);
    @(posedge clk); #1;
    chk("add_r3_written", dut.rf[3], 32'h8000_0000);
    chk("add_valid_drop", 32'(result_valid), 32'd0);

    // Back-to-back SUB then ADD forwarding the SUB result
    defaults(); alu_op = 3'b001; a_addr = 4'd1; b_addr = 4'd2; set_flags = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_ready", 32'(in_ready), 32'd1);
    defaults(); alu_op = 3'b000; fwd_a = 2'b01; b_addr = 4'd2; set_flags = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("sub_result", result, 32'h7FFF_FFFE);
    chk("sub_valid", 32'(result_valid), 32'd1);
    chk("sub_status", 32'(status), 32'b0010);
    @(posedge clk); #1;
    chk("fwd_add_result", result, 32'h7FFF_FFFF);
    chk("fwd_add_valid", 32'(result_valid), 32'd1);
    chk("fwd_add_status", 32'(status), 32'b0000);
    @(posedge clk); #1;
    chk("b2b_valid_drop", 32'(result_valid), 32'd0);

    // Shifts through MOV
    defaults(); alu_op = 3'b101; fwd_b = 2'b11; imm = 32'h8000_0000;
    shift_op = 2'b10; shift_imm = 8'd40;
    run_op("asr_40", 32'hFFFF_FFFF);
    defaults(); alu_op = 3'b101; fwd_b = 2'b11; imm = 32'h1234_5678;
    shift_op = 2'b11; sel_shift_reg = 1'b1; s_addr = 4'd6;
    run_op("ror_36", 32'h8123_4567);
    defaults(); alu_op = 3'b101; fwd_b = 2'b11; imm = 32'hFFFF_FFFF;
    shift_op = 2'b00; shift_imm = 8'd32; set_flags = 1'b1;
    run_op("lsl_32", 32'd0);
    chk("lsl_32_status", 32'(status), 32'b0100);
    defaults(); alu_op = 3'b101; fwd_b = 2'b11; imm = 32'hA5A5_A5A5;
    shift_op = 2'b01; sel_shift_reg = 1'b1; fwd_s = 2'b11; shift_imm = 8'd8;
    run_op("lsr_0", 32'hA5A5_A5A5);

    // ADD setting C and V, operand A from ldr_data
    defaults(); fwd_a = 2'b10; ldr_data = 32'h8000_0000; fwd_b = 2'b11; imm = 32'h8000_0000;
    set_flags = 1'b1;
    run_op("add_cv", 32'd0);
    chk("add_cv_status", 32'(status), 32'b0111);

    // MUL: B unshifted despite shift_imm, C/V preserved, other ops ignored while busy
    defaults(); mul = 1'b1; fwd_a = 2'b10; ldr_data = 32'h0000_FFFF; fwd_b = 2'b11;
    imm = 32'h0001_0001; shift_imm = 8'd4; set_flags = 1'b1; wb_en = 1'b1; wb_addr = 4'd7;
    issue();
    chk("mul_ready_s1", 32'(in_ready), 32'd0);
    defaults(); a_addr = 4'd1; b_addr = 4'd2; in_valid = 1'b1;
    n_edges = 0; ready_seen = 0;
    while (!result_valid && n_edges < 100) begin
      @(posedge clk); #1;
      n_edges++;
      if (in_ready && !result_valid) ready_seen++;
    end
    in_valid = 1'b0;
    chk("mul_latency", 32'(n_edges), 32'd33);
    chk("mul_ready_low", 32'(ready_seen), 32'd0);
    chk("mul_result", result, 32'hFFFF_FFFF);
    chk("mul_status", 32'(status), 32'b1011);
    @(posedge clk); #1;
    chk("mul_r7", dut.rf[7], 32'hFFFF_FFFF);
    chk("mul_ignored_offer", 32'(result_valid), 32'd0);

    // Same-cycle result and ldr writes to r5
    defaults(); a_addr = 4'd1; b_addr = 4'd2; wb_en = 1'b1; wb_addr = 4'd5;
    run_op("collide_result", 32'h8000_0000);
    ldr_en = 1'b1; ldr_addr = 4'd5; ldr_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    ldr_en = 1'b0;
    chk("collide_r5", dut.rf[5], 32'h8000_0000);

    // Reset in the middle of a multiply
    defaults(); mul = 1'b1; fwd_a = 2'b11; pc = 11'd3; fwd_b = 2'b11; imm = 32'd5;
    set_flags = 1'b1; wb_en = 1'b1; wb_addr = 4'd8;
    issue();
    repeat (10) @(posedge clk);
    #1;
    chk("mul_busy_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_status", 32'(status), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_r7", dut.rf[7], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (result_valid) rv_seen++;
    end
    chk("abort_no_valid", 32'(rv_seen), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_status_after", 32'(status), 32'd0);
    chk("abort_r8", dut.rf[8], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
